// File: rtl/preproc_axil_regs.sv
// AXI4-Lite register file for the preprocessing stage: OFFSET, SEL_SOURCE, CTRL and a read-only
// STATUS word, exported as static config outputs. Read and write channels run independent FSMs.
module preproc_axil_regs #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 4,
  parameter int unsigned OFFSET_WIDTH = 16,
  parameter int unsigned SEL_WIDTH    = 5,
  parameter logic [31:0] VERSION      = 32'h5052_0001
) (
  input  logic                      s_axi_aclk,
  input  logic                      s_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic [OFFSET_WIDTH-1:0]   offset_o,
  output logic [SEL_WIDTH-1:0]      sel_source_o,
  output logic                      enable_o,
  output logic                      cfg_update_o
);

  localparam int unsigned STRB_WIDTH  = DATA_WIDTH / 8;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} wstate_e;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_e;

  wstate_e                   wstate_q, wstate_d;
  rstate_e                   rstate_q, rstate_d;
  logic                      aw_held_q, aw_held_d;
  logic [1:0]                aw_addr_q, aw_addr_d;
  logic                      w_held_q, w_held_d;
  logic [DATA_WIDTH-1:0]     w_data_q, w_data_d;
  logic [STRB_WIDTH-1:0]     w_strb_q, w_strb_d;
  logic                      awready_q, awready_d;
  logic                      wready_q, wready_d;
  logic                      bvalid_q, bvalid_d;
  logic [1:0]                bresp_q, bresp_d;
  logic                      cfg_update_q, cfg_update_d;
  logic [OFFSET_WIDTH-1:0]   offset_q, offset_d;
  logic [SEL_WIDTH-1:0]      sel_q, sel_d;
  logic                      enable_q, enable_d;
  logic                      arready_q, arready_d;
  logic                      rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
  logic                      aw_hs_s, w_hs_s;
  logic [DATA_WIDTH-1:0]     rd_word_s;
  logic                      addr_lsb_unused_s;

  // Byte-lane merge: lane k of the new word replaces the old one only when strb[k] is set.
  function automatic logic [DATA_WIDTH-1:0] merge_bytes(input logic [DATA_WIDTH-1:0] old_v,
                                                        input logic [DATA_WIDTH-1:0] new_v,
                                                        input logic [STRB_WIDTH-1:0] strb);
    logic [DATA_WIDTH-1:0] res;
    res = old_v;
    for (int k = 0; k < int'(STRB_WIDTH); k++) begin
      res[8*k +: 8] = strb[k] ? new_v[8*k +: 8] : old_v[8*k +: 8];
    end
    return res;
  endfunction

  assign addr_lsb_unused_s = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  // Read data mux over the word index; unimplemented bits read as zero.
  always_comb begin
    rd_word_s = '0;
    case (s_axi_araddr[3:2])
      2'd0:    rd_word_s = DATA_WIDTH'(offset_q);
      2'd1:    rd_word_s = DATA_WIDTH'(sel_q);
      2'd2:    rd_word_s = DATA_WIDTH'(enable_q);
      2'd3:    rd_word_s = DATA_WIDTH'(VERSION);
      default: rd_word_s = '0;
    endcase
  end

  // Write FSM: AW and W are latched independently; the register commits once both are held.
  always_comb begin
    aw_hs_s      = s_axi_awvalid && awready_q;
    w_hs_s       = s_axi_wvalid && wready_q;
    wstate_d     = wstate_q;
    aw_held_d    = aw_held_q | aw_hs_s;
    aw_addr_d    = aw_hs_s ? s_axi_awaddr[3:2] : aw_addr_q;
    w_held_d     = w_held_q | w_hs_s;
    w_data_d     = w_hs_s ? s_axi_wdata : w_data_q;
    w_strb_d     = w_hs_s ? s_axi_wstrb : w_strb_q;
    awready_d    = awready_q;
    wready_d     = wready_q;
    bvalid_d     = bvalid_q;
    bresp_d      = bresp_q;
    cfg_update_d = 1'b0;
    offset_d     = offset_q;
    sel_d        = sel_q;
    enable_d     = enable_q;
    case (wstate_q)
      W_IDLE: begin
        if (aw_held_d && w_held_d) begin
          wstate_d  = W_RESP;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          bvalid_d  = 1'b1;
          bresp_d   = RESP_OKAY;
          case (aw_addr_d)
            2'd0: begin
              offset_d     = OFFSET_WIDTH'(merge_bytes(DATA_WIDTH'(offset_q), w_data_d, w_strb_d));
              cfg_update_d = 1'b1;
            end
            2'd1: begin
              sel_d        = SEL_WIDTH'(merge_bytes(DATA_WIDTH'(sel_q), w_data_d, w_strb_d));
              cfg_update_d = 1'b1;
            end
            2'd2: begin
              enable_d     = w_strb_d[0] ? w_data_d[0] : enable_q;
              cfg_update_d = 1'b1;
            end
            default: begin
              bresp_d = RESP_SLVERR;
            end
          endcase
        end else begin
          awready_d = !aw_held_d;
          wready_d  = !w_held_d;
        end
      end
      W_RESP: begin
        if (s_axi_bready) begin
          wstate_d  = W_IDLE;
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end else begin
          bvalid_d  = 1'b1;
          awready_d = 1'b0;
          wready_d  = 1'b0;
        end
      end
      default: begin
        wstate_d  = W_IDLE;
        bvalid_d  = 1'b0;
        awready_d = 1'b0;
        wready_d  = 1'b0;
      end
    endcase
  end

  // Read FSM: one outstanding read, data captured at the AR handshake and held until taken.
  always_comb begin
    rstate_d  = rstate_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    case (rstate_q)
      R_IDLE: begin
        if (s_axi_arvalid && arready_q) begin
          rstate_d  = R_DATA;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rdata_d   = rd_word_s;
        end else begin
          arready_d = 1'b1;
        end
      end
      R_DATA: begin
        if (s_axi_rready) begin
          rstate_d  = R_IDLE;
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
        end else begin
          rvalid_d  = 1'b1;
        end
      end
      default: begin
        rstate_d  = R_IDLE;
        arready_d = 1'b0;
        rvalid_d  = 1'b0;
      end
    endcase
  end

  // State and register update; reset discards any in-flight handshake.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      wstate_q     <= W_IDLE;
      rstate_q     <= R_IDLE;
      aw_held_q    <= 1'b0;
      aw_addr_q    <= 2'b00;
      w_held_q     <= 1'b0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      awready_q    <= 1'b0;
      wready_q     <= 1'b0;
      bvalid_q     <= 1'b0;
      bresp_q      <= 2'b00;
      cfg_update_q <= 1'b0;
      offset_q     <= '0;
      sel_q        <= '0;
      enable_q     <= 1'b0;
      arready_q    <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
    end else begin
      wstate_q     <= wstate_d;
      rstate_q     <= rstate_d;
      aw_held_q    <= aw_held_d;
      aw_addr_q    <= aw_addr_d;
      w_held_q     <= w_held_d;
      w_data_q     <= w_data_d;
      w_strb_q     <= w_strb_d;
      awready_q    <= awready_d;
      wready_q     <= wready_d;
      bvalid_q     <= bvalid_d;
      bresp_q      <= bresp_d;
      cfg_update_q <= cfg_update_d;
      offset_q     <= offset_d;
      sel_q        <= sel_d;
      enable_q     <= enable_d;
      arready_q    <= arready_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = RESP_OKAY;
  assign offset_o      = offset_q;
  assign sel_source_o  = sel_q;
  assign enable_o      = enable_q;
  assign cfg_update_o  = cfg_update_q;

endmodule

// File: tb/tb_preproc_axil_regs.sv
// Scoreboard bench for preproc_axil_regs: directed AXI-Lite transactions push expected
// responses into queues; a negedge monitor pops and compares on every B/R handshake.
module tb_preproc_axil_regs;
  logic        clk = 1'b0;
  logic        s_axi_aresetn;
  logic [3:0]  s_axi_awaddr;
  logic        s_axi_awvalid, s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid, s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid, s_axi_bready;
  logic [3:0]  s_axi_araddr;
  logic        s_axi_arvalid, s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid, s_axi_rready;
  logic [15:0] offset_o;
  logic [4:0]  sel_source_o;
  logic        enable_o, cfg_update_o;

  localparam logic [31:0] VERSION = 32'h5052_0001;

  int checks = 0;
  int passes = 0;
  int cfg_cnt = 0;
  int c0;
  logic [1:0]  exp_b[$];
  logic [31:0] exp_r[$];

  always #5 clk = ~clk;

  preproc_axil_regs dut (
    .s_axi_aclk(clk), .s_axi_aresetn(s_axi_aresetn),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .offset_o(offset_o),
    .sel_source_o(sel_source_o), .enable_o(enable_o), .cfg_update_o(cfg_update_o)
  );

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endfunction

  function automatic void fail_now(input string name);
    checks++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endfunction

  // Monitor: compare each accepted response against the scoreboard; count config pulses.
  always @(negedge clk) begin
    if (s_axi_aresetn) begin
      if (cfg_update_o) cfg_cnt++;
      if (s_axi_bvalid && s_axi_bready) begin
        if (exp_b.size() == 0) begin
          checks++;
          $display("FAIL bresp_unexpected: got 0x%0h, expected no response", s_axi_bresp);
        end else check("bresp", 32'(s_axi_bresp), 32'(exp_b.pop_front()));
      end
      if (s_axi_rvalid && s_axi_rready) begin
        if (exp_r.size() == 0) begin
          checks++;
          $display("FAIL rdata_unexpected: got 0x%08h, expected no response", s_axi_rdata);
        end else check("rdata", s_axi_rdata, exp_r.pop_front());
        check("rresp", 32'(s_axi_rresp), 32'd0);
      end
    end
  end

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] er, input int w_lead);
    bit aw_done = 1'b0, w_done = 1'b0, aw_fire, w_fire;
    int n = 0;
    exp_b.push_back(er);
    s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
    s_axi_wvalid = 1'b1; s_axi_awvalid = (w_lead == 0);
    while (!(aw_done && w_done)) begin
      @(negedge clk);
      if (w_done && !aw_done) check("wready_low_while_aw_pending", 32'(s_axi_wready), 32'd0);
      aw_fire = s_axi_awvalid && s_axi_awready;
      w_fire  = s_axi_wvalid && s_axi_wready;
      @(posedge clk); #1;
      if (aw_fire) begin aw_done = 1'b1; s_axi_awvalid = 1'b0; end
      if (w_fire) begin w_done = 1'b1; s_axi_wvalid = 1'b0; end
      n++;
      if (!aw_done && n >= w_lead) s_axi_awvalid = 1'b1;
      if (n > 40) begin
        fail_now("write_handshake");
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_b();
    int n = 0;
    forever begin
      @(negedge clk);
      if (s_axi_bvalid && s_axi_bready) break;
      n++;
      if (n > 40) begin fail_now("bvalid"); break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [3:0] a, input logic [31:0] e);
    bit fire;
    int n = 0;
    exp_r.push_back(e);
    s_axi_araddr = a; s_axi_arvalid = 1'b1;
    forever begin
      @(negedge clk);
      fire = s_axi_arvalid && s_axi_arready;
      @(posedge clk); #1;
      if (fire) begin s_axi_arvalid = 1'b0; break; end
      n++;
      if (n > 40) begin fail_now("arready"); s_axi_arvalid = 1'b0; break; end
    end
  endtask

  task automatic wait_r();
    int n = 0;
    forever begin
      @(negedge clk);
      if (s_axi_rvalid && s_axi_rready) break;
      n++;
      if (n > 40) begin fail_now("rvalid"); break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] er);
    axi_write(a, d, s, er, 0);
    wait_b();
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] e);
    axi_read(a, e);
    wait_r();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    s_axi_aresetn = 1'b0; s_axi_awaddr = 4'h0; s_axi_awvalid = 1'b0; s_axi_wdata = 32'h0;
    s_axi_wstrb = 4'h0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b1; s_axi_araddr = 4'h0;
    s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", 32'(s_axi_awready), 32'd0);
    check("rst_arready", 32'(s_axi_arready), 32'd0);
    check("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
    check("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
    @(negedge clk); s_axi_aresetn = 1'b1;
    @(posedge clk); #1;
    check("ready_after_release", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'd7);

    // Reset values and STATUS
    rd(4'h0, 32'h0); rd(4'h4, 32'h0); rd(4'h8, 32'h0); rd(4'hC, VERSION);
    check("rst_cfg_outputs", 32'({offset_o, sel_source_o, enable_o, cfg_update_o}), 32'd0);

    // AW and W in the same cycle
    c0 = cfg_cnt;
    axi_write(4'h0, 32'h0000_1234, 4'hF, 2'b00, 0);
    check("offset_after_write", 32'(offset_o), 32'h1234);
    check("cfg_update_pulse_high", 32'(cfg_update_o), 32'd1);
    wait_b();
    repeat (2) @(posedge clk);
    #1;
    check("cfg_update_single_pulse", 32'(cfg_cnt - c0), 32'd1);
    rd(4'h0, 32'h0000_1234);

    // W three cycles ahead of AW, low byte only
    axi_write(4'h1, 32'h0000_00FF, 4'b0001, 2'b00, 3);
    wait_b();
    check("offset_strb_low_byte", 32'(offset_o), 32'h12FF);
    rd(4'h0, 32'h0000_12FF);

    // All strobes off: no change, OKAY, still a pulse
    c0 = cfg_cnt;
    wr(4'h0, 32'hFFFF_FFFF, 4'b0000, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    check("offset_strb_zero", 32'(offset_o), 32'h12FF);
    check("cfg_pulse_strb_zero", 32'(cfg_cnt - c0), 32'd1);

    // Response back-pressure with a second write stalled behind it
    s_axi_bready = 1'b0;
    axi_write(4'h8, 32'h0000_0001, 4'hF, 2'b00, 0);
    check("enable_after_write", 32'(enable_o), 32'd1);
    fork
      axi_write(4'h4, 32'h0000_0003, 4'hF, 2'b00, 0);
      begin
        repeat (5) begin
          @(negedge clk);
          check("stall_bvalid", 32'(s_axi_bvalid), 32'd1);
          check("stall_bresp", 32'(s_axi_bresp), 32'd0);
          check("stall_readies", 32'({s_axi_awready, s_axi_wready}), 32'd0);
        end
        check("sel_unchanged_during_stall", 32'(sel_source_o), 32'd0);
        @(posedge clk); #1;
        s_axi_bready = 1'b1;
      end
    join
    wait_b();
    check("sel_after_stalled_write", 32'(sel_source_o), 32'd3);

    // Unimplemented bits and read-only STATUS
    wr(4'h4, 32'hFFFF_FFFF, 4'hF, 2'b00);
    check("sel_all_ones", 32'(sel_source_o), 32'h1F);
    rd(4'h4, 32'h0000_001F);
    c0 = cfg_cnt;
    wr(4'hC, 32'hDEAD_BEEF, 4'hF, 2'b10);
    repeat (2) @(posedge clk);
    #1;
    check("no_pulse_on_status_write", 32'(cfg_cnt - c0), 32'd0);
    check("regs_after_status_write", 32'({offset_o, sel_source_o, enable_o}), {16'h12FF, 5'h1F, 1'b1});
    rd(4'hC, VERSION);

    // Reset with B and R responses pending
    s_axi_bready = 1'b0; s_axi_rready = 1'b0;
    axi_write(4'h0, 32'h0000_ABCD, 4'hF, 2'b00, 0);
    axi_read(4'h8, 32'h0000_0001);
    @(negedge clk);
    check("pending_b_and_r", 32'({s_axi_bvalid, s_axi_rvalid}), 32'd3);
    #2 s_axi_aresetn = 1'b0;
    #1;
    check("abort_b_and_r", 32'({s_axi_bvalid, s_axi_rvalid}), 32'd0);
    check("abort_cfg_outputs", 32'({offset_o, sel_source_o, enable_o, cfg_update_o}), 32'd0);
    check("abort_readies", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'd0);
    exp_b.delete(); exp_r.delete();
    s_axi_bready = 1'b1; s_axi_rready = 1'b1;
    @(negedge clk); s_axi_aresetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rd(4'h0, 32'h0); rd(4'h4, 32'h0); rd(4'h8, 32'h0);

    repeat (2) @(posedge clk);
    check("b_queue_drained", 32'(exp_b.size()), 32'd0);
    check("r_queue_drained", 32'(exp_r.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
